// File: rtl/frontend_redirect_if.sv
// Redirect request/broadcast bundle between the frontend requesters and frontend_redirect_ctrl.
// master = requesters and consumers (backend, predecode, BPU, FSQ, ICache); slave = the controller.
interface frontend_redirect_if #(
  parameter int VADDR_SIZE = 39,
  parameter int FSQ_WIDTH  = 5,
  parameter int PRED_WIDTH = 4
);
  // Handshake: requests are valid-only pulses with no ready; a request that loses arbitration is dropped
  // and must be re-asserted. Acceptance is visible as pd_accept (same cycle) or redirect (next cycle).
  logic                  be_valid;
  logic [VADDR_SIZE-1:0] be_pc;
  logic [FSQ_WIDTH-1:0]  be_fsq_idx;
  logic [PRED_WIDTH-1:0] be_offset;
  logic                  be_mem;
  logic                  pd_valid;
  logic [VADDR_SIZE-1:0] pd_pc;
  logic [FSQ_WIDTH-1:0]  pd_fsq_idx;
  logic                  bpu_valid;
  logic [VADDR_SIZE-1:0] bpu_pc;
  logic                  ibuf_full;

  logic                  redirect;
  logic [1:0]            redirect_src;
  logic [VADDR_SIZE-1:0] redirect_pc;
  logic [FSQ_WIDTH-1:0]  redirect_fsq_idx;
  logic [PRED_WIDTH-1:0] redirect_offset;
  logic                  redirect_mem;
  logic                  pd_accept;
  logic                  fetch_stall;
  logic                  busy;

  modport master (
    output be_valid, be_pc, be_fsq_idx, be_offset, be_mem,
    output pd_valid, pd_pc, pd_fsq_idx, bpu_valid, bpu_pc, ibuf_full,
    input  redirect, redirect_src, redirect_pc, redirect_fsq_idx, redirect_offset,
    input  redirect_mem, pd_accept, fetch_stall, busy
  );

  modport slave (
    input  be_valid, be_pc, be_fsq_idx, be_offset, be_mem,
    input  pd_valid, pd_pc, pd_fsq_idx, bpu_valid, bpu_pc, ibuf_full,
    output redirect, redirect_src, redirect_pc, redirect_fsq_idx, redirect_offset,
    output redirect_mem, pd_accept, fetch_stall, busy
  );
endinterface

// File: rtl/frontend_redirect_ctrl.sv
// Frontend redirect arbiter (backend > predecode > bpu) with a registered flush and fixed recovery stall.
// Optional REDIRECT_PERF_EN adds saturating per-source accept counters on perf_be/perf_pd/perf_bpu.
module frontend_redirect_ctrl #(
  parameter int VADDR_SIZE     = 39,
  parameter int FSQ_WIDTH      = 5,
  parameter int PRED_WIDTH     = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  frontend_redirect_if.slave   rif,
  output logic [1:0]           dbg_state
`ifdef REDIRECT_PERF_EN
  ,
  output logic [31:0]          perf_be,
  output logic [31:0]          perf_pd,
  output logic [31:0]          perf_bpu
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_BE   = 2'd1;
  localparam logic [1:0] SRC_PD   = 2'd2;
  localparam logic [1:0] SRC_BPU  = 2'd3;
  localparam int         CNT_W    = (RECOVER_CYCLES < 2) ? 1 : $clog2(RECOVER_CYCLES + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             block_pd;
  logic             be_acc, pd_acc, bpu_acc, any_acc;
  logic [1:0]       src_sel;

  // A recovery started by backend or predecode may only be overridden by the backend;
  // a BPU-sourced recovery can still be corrected by predecode.
  always_comb begin
    block_pd = (state != IDLE) && (rif.redirect_src != SRC_BPU);
    be_acc   = rif.be_valid;
    pd_acc   = rif.pd_valid & ~rif.ibuf_full & ~rif.be_valid & ~block_pd;
    bpu_acc  = rif.bpu_valid & ~be_acc & ~pd_acc & (state == IDLE);
    any_acc  = be_acc | pd_acc | bpu_acc;
    src_sel  = SRC_NONE;
    if (be_acc)       src_sel = SRC_BE;
    else if (pd_acc)  src_sel = SRC_PD;
    else if (bpu_acc) src_sel = SRC_BPU;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (any_acc) state_nxt = FLUSH;
      end
      FLUSH: begin
        state_nxt = RECOVER;
        cnt_nxt   = CNT_W'(RECOVER_CYCLES);
      end
      RECOVER: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Any accepted request restarts the flush; the counter reloads on leaving FLUSH.
    if (any_acc) begin
      state_nxt = FLUSH;
      cnt_nxt   = cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Payload holds between redirects; offset/mem only carry meaning for backend redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rif.redirect_src     <= SRC_NONE;
      rif.redirect_pc      <= '0;
      rif.redirect_fsq_idx <= '0;
      rif.redirect_offset  <= '0;
      rif.redirect_mem     <= 1'b0;
    end else if (any_acc) begin
      rif.redirect_src <= src_sel;
      if (be_acc) begin
        rif.redirect_pc      <= rif.be_pc;
        rif.redirect_fsq_idx <= rif.be_fsq_idx;
        rif.redirect_offset  <= rif.be_offset;
        rif.redirect_mem     <= rif.be_mem;
      end else if (pd_acc) begin
        rif.redirect_pc      <= rif.pd_pc;
        rif.redirect_fsq_idx <= rif.pd_fsq_idx;
        rif.redirect_offset  <= '0;
        rif.redirect_mem     <= 1'b0;
      end else begin
        rif.redirect_pc      <= rif.bpu_pc;
        rif.redirect_fsq_idx <= '0;
        rif.redirect_offset  <= '0;
        rif.redirect_mem     <= 1'b0;
      end
    end
  end

  assign rif.redirect    = (state == FLUSH);
  assign rif.fetch_stall = (state != IDLE);
  assign rif.busy        = (state != IDLE);
  assign rif.pd_accept   = pd_acc & ~rst;
  assign dbg_state       = state;

`ifdef REDIRECT_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_be  <= '0;
      perf_pd  <= '0;
      perf_bpu <= '0;
    end else begin
      if (be_acc  && (perf_be  != '1)) perf_be  <= perf_be  + 32'd1;
      if (pd_acc  && (perf_pd  != '1)) perf_pd  <= perf_pd  + 32'd1;
      if (bpu_acc && (perf_bpu != '1)) perf_bpu <= perf_bpu + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frontend_redirect_ctrl.sv
// Bench for frontend_redirect_ctrl: directed scenarios plus random traffic against a stall-countdown model.
module tb_frontend_redirect_ctrl;
  localparam int VA = 39;
  localparam int FW = 5;
  localparam int PW = 4;
  localparam int RC = 2;
  localparam int OW = 1 + 2 + VA + FW + PW + 1 + 1 + 1;

  typedef struct packed {
    logic          be;
    logic [VA-1:0] be_pc;
    logic [FW-1:0] be_idx;
    logic [PW-1:0] be_off;
    logic          be_mem;
    logic          pd;
    logic [VA-1:0] pd_pc;
    logic [FW-1:0] pd_idx;
    logic          bpu;
    logic [VA-1:0] bpu_pc;
    logic          ibuf;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         fails  = 0;

  frontend_redirect_if #(.VADDR_SIZE(VA), .FSQ_WIDTH(FW), .PRED_WIDTH(PW)) rif();

`ifdef REDIRECT_PERF_EN
  logic [31:0] perf_be, perf_pd, perf_bpu;
`endif

  frontend_redirect_ctrl #(
    .VADDR_SIZE(VA), .FSQ_WIDTH(FW), .PRED_WIDTH(PW), .RECOVER_CYCLES(RC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rif       (rif),
    .dbg_state (dbg_state)
`ifdef REDIRECT_PERF_EN
    ,
    .perf_be   (perf_be),
    .perf_pd   (perf_pd),
    .perf_bpu  (perf_bpu)
`endif
  );

  always #5 clk = ~clk;

  logic [OW-1:0] obs_vec;
  assign obs_vec = {rif.redirect, rif.redirect_src, rif.redirect_pc, rif.redirect_fsq_idx,
                    rif.redirect_offset, rif.redirect_mem, rif.fetch_stall, rif.busy};

  // Reference: after an accepted request the frontend is stalled for 1 + RC cycles,
  // the first of which carries the redirect pulse.
  int            m_stall;
  logic          m_redir;
  logic [1:0]    m_src;
  logic [VA-1:0] m_pc;
  logic [FW-1:0] m_idx;
  logic [PW-1:0] m_off;
  logic          m_mem;
  int            m_cnt_be, m_cnt_pd, m_cnt_bpu;

  task automatic model_reset();
    m_stall = 0; m_redir = 1'b0; m_src = 2'd0; m_pc = '0; m_idx = '0; m_off = '0; m_mem = 1'b0;
    m_cnt_be = 0; m_cnt_pd = 0; m_cnt_bpu = 0;
  endtask

  function automatic logic model_pd_ok();
    return rif.pd_valid && !rif.ibuf_full && !rif.be_valid && (m_stall == 0 || m_src == 2'd3);
  endfunction

  function automatic logic [OW-1:0] exp_vec();
    return {m_redir, m_src, m_pc, m_idx, m_off, m_mem, (m_stall > 0), (m_stall > 0)};
  endfunction

  task automatic model_step();
    int win;
    win = 0;
    if (rif.be_valid)                         win = 1;
    else if (model_pd_ok())                   win = 2;
    else if (rif.bpu_valid && m_stall == 0)   win = 3;
    m_redir = (win != 0);
    if (win != 0) begin
      m_stall = 1 + RC;
      m_src   = 2'(win);
      m_pc    = (win == 1) ? rif.be_pc : (win == 2) ? rif.pd_pc : rif.bpu_pc;
      m_idx   = (win == 1) ? rif.be_fsq_idx : (win == 2) ? rif.pd_fsq_idx : '0;
      m_off   = (win == 1) ? rif.be_offset : '0;
      m_mem   = (win == 1) && rif.be_mem;
      if (win == 1) m_cnt_be++;
      else if (win == 2) m_cnt_pd++;
      else m_cnt_bpu++;
    end else if (m_stall > 0) begin
      m_stall--;
    end
  endtask

  function automatic logic [VA-1:0] rand_pc();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[VA-1:0];
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s.be = 1'b0; s.be_pc = rand_pc(); s.be_idx = FW'($urandom_range(0, 31));
    s.be_off = PW'($urandom_range(0, 15)); s.be_mem = 1'($urandom_range(0, 1));
    s.pd = 1'b0; s.pd_pc = rand_pc(); s.pd_idx = FW'($urandom_range(0, 31));
    s.bpu = 1'b0; s.bpu_pc = rand_pc(); s.ibuf = 1'($urandom_range(0, 1));
    return s;
  endfunction

  task automatic apply(input stim_t s);
    @(negedge clk);
    rif.be_valid = s.be; rif.be_pc = s.be_pc; rif.be_fsq_idx = s.be_idx;
    rif.be_offset = s.be_off; rif.be_mem = s.be_mem;
    rif.pd_valid = s.pd; rif.pd_pc = s.pd_pc; rif.pd_fsq_idx = s.pd_idx;
    rif.bpu_valid = s.bpu; rif.bpu_pc = s.bpu_pc; rif.ibuf_full = s.ibuf;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    stim_t s;
    s = idle_stim(); s.pd = 1'b1; s.ibuf = 1'b0; s.be = 1'b1; s.bpu = 1'b1;
    rst = 1'b1;
    apply(s);
    model_reset();
    checks++;
    if (rif.pd_accept !== 1'b0) begin
      fails++; $display("FAIL reset pd_accept got %0b exp 0", rif.pd_accept);
    end
    checks++;
    if (obs_vec !== '0) begin
      fails++; $display("FAIL reset outputs got %h exp 0", obs_vec);
    end
`ifdef REDIRECT_PERF_EN
    checks++;
    if ({perf_be, perf_pd, perf_bpu} !== 96'd0) begin
      fails++; $display("FAIL reset perf got %0d/%0d/%0d exp 0/0/0", perf_be, perf_pd, perf_bpu);
    end
`endif
    apply(idle_stim());
    rst = 1'b0;
    repeat (3) begin
      advance();
      checks++;
      if (obs_vec !== exp_vec()) begin
        fails++; $display("FAIL reset idle got %h exp %h", obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_backend();
    stim_t q[$];
    stim_t s;
    s = idle_stim(); s.be = 1'b1; s.be_pc = 39'h00_8000_1000; s.be_idx = 5'd3; s.be_off = 4'd2; s.be_mem = 1'b1;
    q.push_back(s);
    repeat (5) q.push_back(idle_stim());
    foreach (q[i]) begin
      apply(q[i]);
      checks++;
      if (rif.pd_accept !== model_pd_ok()) begin
        fails++; $display("FAIL backend pd_accept cyc %0d got %0b exp %0b", i, rif.pd_accept, model_pd_ok());
      end
      advance();
      checks++;
      if (obs_vec !== exp_vec()) begin
        fails++; $display("FAIL backend outputs cyc %0d got %h exp %h", i, obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_all_three();
    stim_t q[$];
    stim_t s;
    s = idle_stim(); s.be = 1'b1; s.pd = 1'b1; s.bpu = 1'b1; s.ibuf = 1'b0; s.pd_idx = s.be_idx;
    q.push_back(s);
    repeat (5) q.push_back(idle_stim());
    foreach (q[i]) begin
      apply(q[i]);
      checks++;
      if (rif.pd_accept !== model_pd_ok()) begin
        fails++; $display("FAIL all_three pd_accept cyc %0d got %0b exp %0b", i, rif.pd_accept, model_pd_ok());
      end
      advance();
      checks++;
      if (obs_vec !== exp_vec()) begin
        fails++; $display("FAIL all_three outputs cyc %0d got %h exp %h", i, obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_ibuf_full();
    stim_t q[$];
    stim_t s;
    s = idle_stim(); s.pd = 1'b1; s.ibuf = 1'b1; q.push_back(s);
    s.ibuf = 1'b0; q.push_back(s);
    repeat (5) q.push_back(idle_stim());
    foreach (q[i]) begin
      apply(q[i]);
      checks++;
      if (rif.pd_accept !== model_pd_ok()) begin
        fails++; $display("FAIL ibuf_full pd_accept cyc %0d got %0b exp %0b", i, rif.pd_accept, model_pd_ok());
      end
      advance();
      checks++;
      if (obs_vec !== exp_vec()) begin
        fails++; $display("FAIL ibuf_full outputs cyc %0d got %h exp %h", i, obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_bpu_then_pd();
    stim_t q[$];
    stim_t s;
    s = idle_stim(); s.bpu = 1'b1; q.push_back(s);
    q.push_back(idle_stim());
    s = idle_stim(); s.pd = 1'b1; s.ibuf = 1'b0; q.push_back(s);
    q.push_back(idle_stim());
    s = idle_stim(); s.pd = 1'b1; s.ibuf = 1'b0; q.push_back(s);
    repeat (5) q.push_back(idle_stim());
    foreach (q[i]) begin
      apply(q[i]);
      checks++;
      if (rif.pd_accept !== model_pd_ok()) begin
        fails++; $display("FAIL bpu_then_pd pd_accept cyc %0d got %0b exp %0b", i, rif.pd_accept, model_pd_ok());
      end
      advance();
      checks++;
      if (obs_vec !== exp_vec()) begin
        fails++; $display("FAIL bpu_then_pd outputs cyc %0d got %h exp %h", i, obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_pd_then_be();
    stim_t q[$];
    stim_t s;
    s = idle_stim(); s.pd = 1'b1; s.ibuf = 1'b0; q.push_back(s);
    q.push_back(idle_stim());
    s = idle_stim(); s.be = 1'b1; q.push_back(s);
    repeat (6) q.push_back(idle_stim());
    foreach (q[i]) begin
      apply(q[i]);
      checks++;
      if (rif.pd_accept !== model_pd_ok()) begin
        fails++; $display("FAIL pd_then_be pd_accept cyc %0d got %0b exp %0b", i, rif.pd_accept, model_pd_ok());
      end
      advance();
      checks++;
      if (obs_vec !== exp_vec()) begin
        fails++; $display("FAIL pd_then_be outputs cyc %0d got %h exp %h", i, obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    stim_t s;
    for (int i = 0; i < 400; i++) begin
      s = idle_stim();
      s.be  = ($urandom_range(0, 7) == 0);
      s.pd  = ($urandom_range(0, 2) == 0);
      s.bpu = ($urandom_range(0, 2) == 0);
      s.ibuf = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) s.pd_idx = s.be_idx;
      apply(s);
      checks++;
      if (rif.pd_accept !== model_pd_ok()) begin
        fails++; $display("FAIL random pd_accept cyc %0d got %0b exp %0b", i, rif.pd_accept, model_pd_ok());
      end
      advance();
      checks++;
      if (obs_vec !== exp_vec()) begin
        fails++; $display("FAIL random outputs cyc %0d got %h exp %h", i, obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_mid_reset();
    stim_t q[$];
    stim_t s;
    s = idle_stim(); s.be = 1'b1; q.push_back(s);
    q.push_back(idle_stim());
    q.push_back(idle_stim());
    foreach (q[i]) begin
      apply(q[i]);
      advance();
      checks++;
      if (obs_vec !== exp_vec()) begin
        fails++; $display("FAIL mid_reset pre cyc %0d got %h exp %h", i, obs_vec, exp_vec());
      end
    end
    // Assert reset between edges while stalled; outputs must clear without a clock.
    #2;
    rif.pd_valid = 1'b1; rif.ibuf_full = 1'b0; rif.be_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs_vec !== '0 || rif.pd_accept !== 1'b0) begin
      fails++; $display("FAIL mid_reset async got %h/%0b exp 0/0", obs_vec, rif.pd_accept);
    end
`ifdef REDIRECT_PERF_EN
    checks++;
    if ({perf_be, perf_pd, perf_bpu} !== 96'd0) begin
      fails++; $display("FAIL mid_reset perf got %0d/%0d/%0d exp 0/0/0", perf_be, perf_pd, perf_bpu);
    end
`endif
    apply(idle_stim());
    rst = 1'b0;
    repeat (3) begin
      advance();
      checks++;
      if (obs_vec !== exp_vec()) begin
        fails++; $display("FAIL mid_reset post got %h exp %h", obs_vec, exp_vec());
      end
      apply(idle_stim());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_backend();
    test_all_three();
    test_ibuf_full();
    test_bpu_then_pd();
    test_pd_then_be();
    test_random();
    test_mid_reset();
    test_backend();
    test_bpu_then_pd();
    test_pd_then_be();
`ifdef REDIRECT_PERF_EN
    checks++;
    if (perf_be !== 32'(m_cnt_be) || perf_pd !== 32'(m_cnt_pd) || perf_bpu !== 32'(m_cnt_bpu)) begin
      fails++;
      $display("FAIL perf_counts got %0d/%0d/%0d exp %0d/%0d/%0d",
               perf_be, perf_pd, perf_bpu, m_cnt_be, m_cnt_pd, m_cnt_bpu);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/frontend_redirect_ctrl.md
Name: frontend_redirect_ctrl

Overview:
Central redirect arbiter and recovery sequencer for the frontend. Collects redirect requests from the backend (commit/execute), the predecode stage (jump/nobranch errors) and the BPU (late-stage override). Selects one per cycle by priority, broadcasts a registered redirect to the BPU, FSQ, ICache and predecode stages, then holds fetch stalled for a fixed recovery window before releasing the pipeline.

Parameters:
VADDR_SIZE, 39, virtual address width
FSQ_WIDTH, 5, FSQ index width
PRED_WIDTH, 4, in-block instruction offset width
RECOVER_CYCLES, 2, stall cycles after any accepted redirect (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
be_valid  in  1  backend redirect request
be_pc  in  VADDR_SIZE  backend target pc
be_fsq_idx  in  FSQ_WIDTH  FSQ entry of redirecting instruction
be_offset  in  PRED_WIDTH  offset inside stream
be_mem  in  1  memory-ordering replay redirect
pd_valid  in  1  predecode redirect request
pd_pc  in  VADDR_SIZE  predecode corrected target
pd_fsq_idx  in  FSQ_WIDTH  stream being corrected
bpu_valid  in  1  BPU late-stage override
bpu_pc  in  VADDR_SIZE  BPU override target
ibuf_full  in  1  instruction buffer full
redirect  out  1  one-cycle global frontend flush
redirect_src  out  2  0=none 1=backend 2=predecode 3=bpu
redirect_pc  out  VADDR_SIZE  restart pc
redirect_fsq_idx  out  FSQ_WIDTH  FSQ index for tail rollback
redirect_offset  out  PRED_WIDTH  offset (backend only, else 0)
redirect_mem  out  1  copy of be_mem for backend redirects, else 0
pd_accept  out  1  combinational: predecode request taken this cycle
fetch_stall  out  1  stall BPU s1/ICache request issue
busy  out  1  FSM not IDLE

Behaviour:
- Reset: all outputs 0, FSM=IDLE, counter=0, latched fields 0; applies mid-recovery immediately.
- Priority per cycle: backend > predecode > bpu. Lower-priority requests losing arbitration are dropped; requesters must re-assert.
- Predecode request eligible only when ibuf_full=0; pd_accept = pd_valid & ~ibuf_full & ~be_valid & ~block_pd.
- Latency: request accepted at cycle N -> redirect=1 with latched pc/idx/offset/mem/src at cycle N+1, for exactly one cycle. Payload outputs hold their value until the next accepted redirect.
- FSM states:
  IDLE: any accepted request -> FLUSH.
  FLUSH (1 cycle; redirect=1): counter loaded with RECOVER_CYCLES -> RECOVER.
  RECOVER: fetch_stall=1; counter decrements each cycle; when counter reaches 1 and no new request is accepted -> IDLE.
- Preemption in RECOVER/FLUSH: backend request always accepted -> FLUSH again (counter reloaded). Predecode request accepted only if current recovery source is bpu (block_pd=1 when source is backend or predecode). BPU requests ignored in FLUSH/RECOVER.
- Backend and predecode with same fsq_idx in same cycle: backend wins, pd_accept=0.
- fetch_stall=1 in FLUSH and RECOVER; 0 in IDLE.
- busy = (state != IDLE).
- redirect_offset/redirect_mem forced 0 for non-backend sources.
- No arithmetic on pc; fsq_idx passed through unmodified, wrap handled downstream.

Optional Feature:
REDIRECT_PERF_EN: when defined, adds three 32-bit saturating counters (be_cnt, pd_cnt, bpu_cnt), incremented on each accepted redirect of that source and reset to 0. They are exposed on extra output ports perf_be, perf_pd, perf_bpu. When not defined, the counters and ports are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then be_valid=1 with pc=0x8000_1000, idx=3, offset=2, mem=1 at cycle 5 -> cycle 6: redirect=1, src=1, pc=0x80001000, idx=3, offset=2, mem=1; fetch_stall=1 cycles 6-8; busy=0 at cycle 9 (RECOVER_CYCLES=2).
- be_valid, pd_valid and bpu_valid all asserted in one cycle -> src=1 only; pd_accept=0; no second redirect follows.
- pd_valid=1 with ibuf_full=1 -> pd_accept=0, no redirect. Drop ibuf_full the next cycle -> pd_accept=1, redirect src=2 one cycle later.
- bpu redirect, then pd_valid during RECOVER -> accepted, second redirect src=2, counter reloaded. pd_valid during a pd-sourced RECOVER -> pd_accept=0.
- Predecode-sourced RECOVER, then be_valid at the second stall cycle -> redirect src=1 next cycle; stall extends RECOVER_CYCLES from the new flush.
- rst asserted mid-RECOVER -> all outputs 0 asynchronously; after release, FSM=IDLE. With REDIRECT_PERF_EN, perf counters are 0 after reset and equal the per-source accept counts after the above sequence.
